// File: rtl/id_branch_resolve_pkg.sv
// Shared constants for the ID-stage branch resolver.
package id_branch_resolve_pkg;

  // Resolver FSM encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STALL   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Stall cycles owed by a producer still in EX (a MEM-stage load owes one as well)
  localparam logic [1:0] LOAD_EX_STALL = 2'd2;
  localparam logic [1:0] ALU_EX_STALL  = 2'd1;

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/id_branch_resolve_if.sv
// Pipeline-side signal bundle of the ID branch resolver.
interface id_branch_resolve_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic             id_beq;
  logic             id_bne;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [WIDTH-1:0] rf_rs_data;
  logic [WIDTH-1:0] rf_rt_data;
  logic [WIDTH-1:0] id_pc4;
  logic [15:0]      id_imm;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [4:0]       ex_rd;
  logic             mem_wreg;
  logic             mem_m2reg;
  logic [4:0]       mem_rd;
  logic [WIDTH-1:0] mem_alu;
  logic             wb_wreg;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_zero;
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] tk_count;

  // Pipeline side: drives the ID/EX/MEM/WB view and the comparator result
  modport master (
    output id_valid, id_beq, id_bne, id_rs, id_rt, rf_rs_data, rf_rt_data,
           id_pc4, id_imm, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg,
           mem_rd, mem_alu, wb_wreg, wb_rd, wb_data, cmp_zero,
    input  cmp_a, cmp_b, stall, redirect, target, br_count, tk_count
  );

  // Resolver side
  modport slave (
    input  id_valid, id_beq, id_bne, id_rs, id_rt, rf_rs_data, rf_rt_data,
           id_pc4, id_imm, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg,
           mem_rd, mem_alu, wb_wreg, wb_rd, wb_data, cmp_zero,
    output cmp_a, cmp_b, stall, redirect, target, br_count, tk_count
  );
endinterface

// File: rtl/id_branch_resolve_fwd_sel.sv
// Per-source-register forwarding mux and hazard stall requirement.
module id_fwd_sel
  import id_branch_resolve_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]       r,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rd,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_alu,
  input  logic             wb_wreg,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] opnd,
  output logic [1:0]       need
);

  logic live;

  // Pick the youngest available producer and count cycles until one becomes available
  always_comb begin
    live = (r != REG_ZERO);
    need = '0;
    opnd = rf_data;
    if (live) begin
      if (ex_wreg && ex_rd == r)
        need = ex_m2reg ? LOAD_EX_STALL : ALU_EX_STALL;
      else if (mem_wreg && mem_m2reg && mem_rd == r)
        need = ALU_EX_STALL;

      if (mem_wreg && !mem_m2reg && mem_rd == r)
        opnd = mem_alu;
      else if (wb_wreg && wb_rd == r)
        opnd = wb_data;
    end
  end

endmodule

// File: rtl/id_branch_resolve.sv
// ID-stage beq/bne resolver: hazard stall, operand forwarding, redirect, statistics.
module id_branch_resolve
  import id_branch_resolve_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  id_branch_resolve_if.slave  bus
);

  logic [1:0]       state;
  logic [1:0]       cnt;
  logic [1:0]       need_rs;
  logic [1:0]       need_rt;
  logic [1:0]       need;
  logic             rst_q;
  logic             live;
  logic             is_br;
  logic             resolve;
  logic             stall;
  logic [WIDTH-1:0] offset;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] tk_q;

  id_fwd_sel #(.WIDTH(WIDTH)) u_fwd_rs (
    .r(bus.id_rs), .rf_data(bus.rf_rs_data),
    .ex_wreg(bus.ex_wreg), .ex_m2reg(bus.ex_m2reg), .ex_rd(bus.ex_rd),
    .mem_wreg(bus.mem_wreg), .mem_m2reg(bus.mem_m2reg), .mem_rd(bus.mem_rd),
    .mem_alu(bus.mem_alu), .wb_wreg(bus.wb_wreg), .wb_rd(bus.wb_rd),
    .wb_data(bus.wb_data), .opnd(bus.cmp_a), .need(need_rs)
  );

  id_fwd_sel #(.WIDTH(WIDTH)) u_fwd_rt (
    .r(bus.id_rt), .rf_data(bus.rf_rt_data),
    .ex_wreg(bus.ex_wreg), .ex_m2reg(bus.ex_m2reg), .ex_rd(bus.ex_rd),
    .mem_wreg(bus.mem_wreg), .mem_m2reg(bus.mem_m2reg), .mem_rd(bus.mem_rd),
    .mem_alu(bus.mem_alu), .wb_wreg(bus.wb_wreg), .wb_rd(bus.wb_rd),
    .wb_data(bus.wb_data), .opnd(bus.cmp_b), .need(need_rt)
  );

  // Decode the current cycle: stall, resolve, and the branch target
  always_comb begin
    need    = max_need(need_rs, need_rt);
    // rst_q keeps stall/redirect quiet the cycle after reset as well as during it
    live    = !rst && !rst_q;
    is_br   = bus.id_valid && (bus.id_beq || bus.id_bne);
    stall   = 1'b0;
    resolve = 1'b0;
    if (live) begin
      case (state)
        ST_IDLE:    if (is_br) begin
                      if (need == 2'd0) resolve = 1'b1;
                      else              stall   = 1'b1;
                    end
        ST_STALL:   stall   = bus.id_valid;
        ST_RESOLVE: resolve = bus.id_valid;
        default:    ;
      endcase
    end
    offset       = {{(WIDTH-18){bus.id_imm[15]}}, bus.id_imm, 2'b00};
    bus.target   = bus.id_pc4 + offset;
    bus.stall    = stall;
    bus.redirect = resolve && (bus.id_beq ? bus.cmp_zero : !bus.cmp_zero);
    bus.br_count = br_q;
    bus.tk_count = tk_q;
  end

  // One-cycle delayed reset used to extend output suppression
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Stall sequencing; hazards are sampled once on entry and the counter runs it out
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (live && is_br && need != 2'd0) begin
            cnt   <= 2'(need - 2'd1);
            state <= (need == LOAD_EX_STALL) ? ST_STALL : ST_RESOLVE;
          end
        end
        ST_STALL: begin
          if (!bus.id_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            if (cnt != 2'd0) cnt <= 2'(cnt - 2'd1);
            if (cnt <= 2'd1) state <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Saturating resolved/taken branch statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      tk_q <= '0;
    end else if (resolve) begin
      if (br_q != '1) br_q <= br_q + CNT_W'(1);
      if (bus.redirect && tk_q != '1) tk_q <= tk_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_branch_resolve.sv
// Self-checking bench for id_branch_resolve: per-cycle model compare plus directed literals.
module tb_id_branch_resolve;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_branch_resolve_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  id_branch_resolve #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value the branch should see for register r: newest non-load producer, else the file
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (bus.mem_wreg && !bus.mem_m2reg && bus.mem_rd == r) return bus.mem_alu;
    if (bus.wb_wreg && bus.wb_rd == r) return bus.wb_data;
    return rf;
  endfunction

  // Cycles until register r's producer reaches a forwardable stage
  function automatic int m_need(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (bus.ex_wreg && bus.ex_rd == r) return bus.ex_m2reg ? 2 : 1;
    if (bus.mem_wreg && bus.mem_m2reg && bus.mem_rd == r) return 1;
    return 0;
  endfunction

  // Behavioural model: a branch either resolves now or owes some stall cycles first
  bit          held     = 0;
  int          owed     = 0;
  bit          post_rst = 0;
  logic [15:0] m_br     = '0;
  logic [15:0] m_tk     = '0;

  always @(negedge clk) begin
    bit e_stall;
    bit e_red;
    bit res;
    int n;
    e_stall = 0;
    e_red   = 0;
    res     = 0;
    if (rst || post_rst) begin
      held = 0;
    end else if (!held) begin
      if (bus.id_valid && (bus.id_beq || bus.id_bne)) begin
        n = (m_need(bus.id_rs) > m_need(bus.id_rt)) ? m_need(bus.id_rs) : m_need(bus.id_rt);
        if (n == 0) res = 1;
        else begin
          e_stall = 1;
          held    = 1;
          owed    = n - 1;
        end
      end
    end else if (!bus.id_valid) begin
      held = 0;
    end else if (owed > 0) begin
      e_stall = 1;
      owed--;
    end else begin
      res  = 1;
      held = 0;
    end
    if (res) e_red = bus.id_beq ? bus.cmp_zero : !bus.cmp_zero;

    chk("cmp_a", bus.cmp_a, m_fwd(bus.id_rs, bus.rf_rs_data));
    chk("cmp_b", bus.cmp_b, m_fwd(bus.id_rt, bus.rf_rt_data));
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("redirect", 32'(bus.redirect), 32'(e_red));
    chk("target", bus.target, bus.id_pc4 + (32'($signed(bus.id_imm)) <<< 2));
    chk("br_count", 32'(bus.br_count), 32'(m_br));
    chk("tk_count", 32'(bus.tk_count), 32'(m_tk));

    if (rst) begin
      m_br     = '0;
      m_tk     = '0;
      post_rst = 1;
    end else begin
      post_rst = 0;
      if (res) begin
        if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
        if (e_red && m_tk != 16'hFFFF) m_tk = m_tk + 16'd1;
      end
    end
  end

  task automatic clr();
    bus.id_valid = 0; bus.id_beq = 0; bus.id_bne = 0;
    bus.id_rs = '0; bus.id_rt = '0;
    bus.rf_rs_data = '0; bus.rf_rt_data = '0;
    bus.id_pc4 = 32'h0000_0400; bus.id_imm = 16'h0010;
    bus.ex_wreg = 0; bus.ex_m2reg = 0; bus.ex_rd = '0;
    bus.mem_wreg = 0; bus.mem_m2reg = 0; bus.mem_rd = '0; bus.mem_alu = '0;
    bus.wb_wreg = 0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  // The bench plays the equality comparator from its own operand model
  task automatic settle();
    bus.cmp_zero = (m_fwd(bus.id_rs, bus.rf_rs_data) == m_fwd(bus.id_rt, bus.rf_rt_data));
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic br_setup(input bit beq, input logic [4:0] rs, input logic [4:0] rt);
    bus.id_valid = 1; bus.id_beq = beq; bus.id_bne = !beq;
    bus.id_rs = rs; bus.id_rt = rt;
  endtask

  initial begin
    clr();
    rst = 1;
    settle();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_redirect", 32'(bus.redirect), 32'd0);
    cyc(); cyc();
    rst = 0;
    settle();
    cyc();
    chk("rst_br_count", 32'(bus.br_count), 32'd0);
    chk("rst_tk_count", 32'(bus.tk_count), 32'd0);

    // beq $1,$2 equal, no hazard: taken same cycle, target pc4-8
    br_setup(1, 5'd1, 5'd2);
    bus.rf_rs_data = 32'h0000_1234; bus.rf_rt_data = 32'h0000_1234;
    bus.id_pc4 = 32'h0000_0100; bus.id_imm = 16'hFFFE;
    settle();
    chk("t1_redirect", 32'(bus.redirect), 32'd1);
    chk("t1_stall", 32'(bus.stall), 32'd0);
    chk("t1_target", bus.target, 32'h0000_00F8);
    cyc();
    clr(); settle();
    chk("t1_br", 32'(bus.br_count), 32'd1);
    chk("t1_tk", 32'(bus.tk_count), 32'd1);
    cyc();

    // bne $3,$4 with EX ALU writing $3: one stall, then MEM forward of 5
    br_setup(0, 5'd3, 5'd4);
    bus.rf_rs_data = 32'h99; bus.rf_rt_data = 32'd5;
    bus.ex_wreg = 1; bus.ex_rd = 5'd3;
    settle();
    chk("t2_stall1", 32'(bus.stall), 32'd1);
    cyc();
    bus.ex_wreg = 0; bus.ex_rd = '0;
    bus.mem_wreg = 1; bus.mem_rd = 5'd3; bus.mem_alu = 32'd5;
    settle();
    chk("t2_stall2", 32'(bus.stall), 32'd0);
    chk("t2_cmp_a", bus.cmp_a, 32'd5);
    chk("t2_redirect", 32'(bus.redirect), 32'd0);
    cyc();
    clr(); settle();
    chk("t2_br", 32'(bus.br_count), 32'd2);
    chk("t2_tk", 32'(bus.tk_count), 32'd1);
    cyc();

    // beq $5,$0 with EX load writing $5: two stalls, then WB forward of 0
    br_setup(1, 5'd5, 5'd0);
    bus.rf_rs_data = 32'hDEAD;
    bus.ex_wreg = 1; bus.ex_m2reg = 1; bus.ex_rd = 5'd5;
    settle();
    chk("t3_stall1", 32'(bus.stall), 32'd1);
    cyc();
    bus.ex_wreg = 0; bus.ex_m2reg = 0; bus.ex_rd = '0;
    bus.mem_wreg = 1; bus.mem_m2reg = 1; bus.mem_rd = 5'd5;
    settle();
    chk("t3_stall2", 32'(bus.stall), 32'd1);
    cyc();
    bus.mem_wreg = 0; bus.mem_m2reg = 0; bus.mem_rd = '0;
    bus.wb_wreg = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'd0;
    settle();
    chk("t3_stall3", 32'(bus.stall), 32'd0);
    chk("t3_cmp_a", bus.cmp_a, 32'd0);
    chk("t3_redirect", 32'(bus.redirect), 32'd1);
    cyc();
    clr(); settle();
    chk("t3_br", 32'(bus.br_count), 32'd3);
    chk("t3_tk", 32'(bus.tk_count), 32'd2);
    cyc();

    // beq $0,$0 with EX writing $0: register zero never stalls
    br_setup(1, 5'd0, 5'd0);
    bus.ex_wreg = 1; bus.ex_rd = 5'd0;
    settle();
    chk("t4_stall", 32'(bus.stall), 32'd0);
    chk("t4_redirect", 32'(bus.redirect), 32'd1);
    cyc();

    // MEM beats WB when both write $8
    br_setup(1, 5'd8, 5'd9);
    bus.rf_rs_data = 32'd1; bus.rf_rt_data = 32'd7;
    bus.mem_wreg = 1; bus.mem_rd = 5'd8; bus.mem_alu = 32'd7;
    bus.wb_wreg = 1; bus.wb_rd = 5'd8; bus.wb_data = 32'd9;
    settle();
    chk("t5_cmp_a", bus.cmp_a, 32'd7);
    chk("t5_redirect", 32'(bus.redirect), 32'd1);
    cyc();
    clr(); settle();
    chk("t5_br", 32'(bus.br_count), 32'd5);
    chk("t5_tk", 32'(bus.tk_count), 32'd4);
    cyc();

    // Flush during a load stall: no redirect, no count
    br_setup(0, 5'd6, 5'd7);
    bus.ex_wreg = 1; bus.ex_m2reg = 1; bus.ex_rd = 5'd6;
    settle();
    chk("t6_stall1", 32'(bus.stall), 32'd1);
    cyc();
    clr(); settle();
    chk("t6_redirect", 32'(bus.redirect), 32'd0);
    cyc();
    settle();
    chk("t6_br", 32'(bus.br_count), 32'd5);
    chk("t6_tk", 32'(bus.tk_count), 32'd4);
    cyc();

    // Reset during the second stall cycle of a load hazard
    br_setup(1, 5'd5, 5'd0);
    bus.ex_wreg = 1; bus.ex_m2reg = 1; bus.ex_rd = 5'd5;
    settle();
    cyc();
    rst = 1;
    settle();
    chk("t7_rst_stall", 32'(bus.stall), 32'd0);
    cyc();
    rst = 0;
    settle();
    chk("t7_stall_after", 32'(bus.stall), 32'd0);
    chk("t7_redirect_after", 32'(bus.redirect), 32'd0);
    chk("t7_br", 32'(bus.br_count), 32'd0);
    chk("t7_tk", 32'(bus.tk_count), 32'd0);
    cyc();
    clr(); settle();
    cyc();

    // Saturation: 2^CNT_W + 3 back-to-back taken branches
    br_setup(1, 5'd0, 5'd0);
    settle();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc();
    clr(); settle();
    chk("sat_br", 32'(bus.br_count), 32'h0000_FFFF);
    chk("sat_tk", 32'(bus.tk_count), 32'h0000_FFFF);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
